// File: rtl/noc_ni_tx_pkg.sv
// Shared widths, flit type codes, FSM states and head-field bit offsets for
// the network-interface transmitter and the router-side head decoder.
package noc_ni_tx_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int X_W        = 1;
  localparam int Y_W        = 2;
  localparam int LEN_W      = 4;
  localparam int SEQ_W      = 8;
  localparam int PAY_W      = DATA_WIDTH - 2;

  // Head fields are packed MSB-first directly below the 2-bit type field.
  localparam int HEAD_DST_X_LSB = DATA_WIDTH - 2 - X_W;
  localparam int HEAD_DST_Y_LSB = HEAD_DST_X_LSB - Y_W;
  localparam int HEAD_SRC_X_LSB = HEAD_DST_Y_LSB - X_W;
  localparam int HEAD_SRC_Y_LSB = HEAD_SRC_X_LSB - Y_W;
  localparam int HEAD_LEN_LSB   = HEAD_SRC_Y_LSB - LEN_W;
  localparam int HEAD_SEQ_LSB   = HEAD_LEN_LSB - SEQ_W;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } tx_state_e;

  // Payload flits are BODY except the last one of the packet, which is TAIL.
  function automatic flit_type_e body_type(input logic last);
    return last ? FT_TAIL : FT_BODY;
  endfunction

endpackage

// File: rtl/noc_ni_tx_if.sv
// PE-side request/payload handshake plus router-facing flit link.
interface noc_ni_tx_if import noc_ni_tx_pkg::*; ();

  logic                  pe_req_valid;
  logic                  pe_req_ready;
  logic [X_W-1:0]        pe_dst_x;
  logic [Y_W-1:0]        pe_dst_y;
  logic [LEN_W-1:0]      pe_len;
  logic                  pe_data_valid;
  logic                  pe_data_ready;
  logic [PAY_W-1:0]      pe_data;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  DATA_VALID_OUT;
  logic                  FULL_IN;
  logic                  busy;
  logic                  tx_done;

  // Environment side: the PE plus the router's backpressure.
  modport master (
    output pe_req_valid, pe_dst_x, pe_dst_y, pe_len,
    output pe_data_valid, pe_data, FULL_IN,
    input  pe_req_ready, pe_data_ready, DATA_OUT, DATA_VALID_OUT, busy, tx_done
  );

  // Transmitter side.
  modport slave (
    input  pe_req_valid, pe_dst_x, pe_dst_y, pe_len,
    input  pe_data_valid, pe_data, FULL_IN,
    output pe_req_ready, pe_data_ready, DATA_OUT, DATA_VALID_OUT, busy, tx_done
  );

endinterface

// File: rtl/noc_ni_tx_head_pack.sv
// Combinational head-flit builder; field positions come from the package so
// the router-side decoder shares the same layout.
module noc_ni_tx_head_pack
  import noc_ni_tx_pkg::*;
#(
  parameter logic [X_W-1:0] SRC_X = '0,
  parameter logic [Y_W-1:0] SRC_Y = '0
) (
  input  flit_type_e            i_type,
  input  logic [X_W-1:0]        i_dst_x,
  input  logic [Y_W-1:0]        i_dst_y,
  input  logic [LEN_W-1:0]      i_len,
  input  logic [SEQ_W-1:0]      i_seq,
  output logic [DATA_WIDTH-1:0] o_flit
);

  // Assemble the head fields; unused LSBs stay zero.
  always_comb begin
    o_flit                              = '0;
    o_flit[DATA_WIDTH-1 -: 2]           = i_type;
    o_flit[HEAD_DST_X_LSB +: X_W]       = i_dst_x;
    o_flit[HEAD_DST_Y_LSB +: Y_W]       = i_dst_y;
    o_flit[HEAD_SRC_X_LSB +: X_W]       = SRC_X;
    o_flit[HEAD_SRC_Y_LSB +: Y_W]       = SRC_Y;
    o_flit[HEAD_LEN_LSB +: LEN_W]       = i_len;
    o_flit[HEAD_SEQ_LSB +: SEQ_W]       = i_seq;
  end

endmodule

// File: rtl/noc_ni_tx.sv
// Network-interface transmitter: turns a PE packet request plus payload
// stream into HEAD/BODY/TAIL flits for the router LOCAL input port, holding
// off while the router signals FULL.
module noc_ni_tx
  import noc_ni_tx_pkg::*;
#(
  parameter logic [X_W-1:0] SRC_X = '0,
  parameter logic [Y_W-1:0] SRC_Y = '0
) (
  input  logic     clk,
  input  logic     rst,
  noc_ni_tx_if.slave bus
);

  tx_state_e             r_state;
  logic [X_W-1:0]        r_dst_x;
  logic [Y_W-1:0]        r_dst_y;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic [SEQ_W-1:0]      r_seq;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_busy;

  logic                  w_len_zero;
  logic                  w_last;
  flit_type_e            w_head_type;
  flit_type_e            w_body_type;
  logic [DATA_WIDTH-1:0] w_head_flit;

  assign w_len_zero  = (r_len == '0);
  assign w_last      = (r_cnt == r_len - LEN_W'(1));
  assign w_head_type = w_len_zero ? FT_HEADTAIL : FT_HEAD;
  assign w_body_type = body_type(w_last);

  noc_ni_tx_head_pack #(
    .SRC_X (SRC_X),
    .SRC_Y (SRC_Y)
  ) u_head_pack (
    .i_type  (w_head_type),
    .i_dst_x (r_dst_x),
    .i_dst_y (r_dst_y),
    .i_len   (r_len),
    .i_seq   (r_seq),
    .o_flit  (w_head_flit)
  );

  // Handshake readies are combinational so the PE sees acceptance in-cycle.
  assign bus.pe_req_ready   = (r_state == ST_IDLE) && !rst;
  assign bus.pe_data_ready  = (r_state == ST_BODY) && !bus.FULL_IN;
  assign bus.DATA_OUT       = r_data;
  assign bus.DATA_VALID_OUT = r_valid;
  assign bus.tx_done        = r_done;
  assign bus.busy           = r_busy;

  // Packet FSM with registered flit output; valid/done default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dst_x <= '0;
      r_dst_y <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_seq   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.pe_req_valid) begin
            r_dst_x <= bus.pe_dst_x;
            r_dst_y <= bus.pe_dst_y;
            r_len   <= bus.pe_len;
            r_state <= ST_HEAD;
            r_busy  <= 1'b1;
          end
        end
        ST_HEAD: begin
          if (!bus.FULL_IN) begin
            r_data  <= w_head_flit;
            r_valid <= 1'b1;
            r_seq   <= r_seq + SEQ_W'(1);
            if (w_len_zero) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt   <= '0;
              r_state <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          // A low payload valid leaves a bubble on the link; the FSM waits.
          if (bus.pe_data_valid && !bus.FULL_IN) begin
            r_data  <= {w_body_type, bus.pe_data};
            r_valid <= 1'b1;
            r_cnt   <= r_cnt + LEN_W'(1);
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_ni_tx.sv
// Directed bench for noc_ni_tx: drives requests/payload after the rising
// edge, observes flits on the falling edge and compares against hand-computed
// flit values.
module tb_noc_ni_tx;
  import noc_ni_tx_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  noc_ni_tx_if bus ();

  noc_ni_tx #(
    .SRC_X (1'b0),
    .SRC_Y (2'b00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Flit monitor and protocol counters.
  logic [31:0] q_flit [$];
  logic        q_done [$];
  int          q_cyc  [$];
  int          viol_valid;
  int          viol_ready;
  int          ready_hi;
  int          full_cycles;
  int          stray_done;
  logic        full_prev;

  initial begin
    cyc = 0; viol_valid = 0; viol_ready = 0; ready_hi = 0;
    full_cycles = 0; stray_done = 0; full_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.DATA_VALID_OUT) begin
      q_flit.push_back(bus.DATA_OUT);
      q_done.push_back(bus.tx_done);
      q_cyc.push_back(cyc);
    end
    if (bus.tx_done && !bus.DATA_VALID_OUT) stray_done <= stray_done + 1;
    if (bus.DATA_VALID_OUT && full_prev)    viol_valid <= viol_valid + 1;
    if (bus.FULL_IN && bus.pe_data_ready)   viol_ready <= viol_ready + 1;
    if (bus.pe_data_ready)                  ready_hi   <= ready_hi + 1;
    if (bus.FULL_IN)                        full_cycles <= full_cycles + 1;
    full_prev <= bus.FULL_IN;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [PAY_W-1:0] pay [16];
  int               acc_cyc;

  // Issue one request with header length len, then stream nsend payload words
  // with gap idle cycles after each accepted word.
  task automatic send_pkt(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy,
                          input logic [LEN_W-1:0] len, input int nsend, input int gap);
    int  n;
    logic ok;
    bus.pe_dst_x     = dx;
    bus.pe_dst_y     = dy;
    bus.pe_len       = len;
    bus.pe_req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.pe_req_ready) break;
      n++;
      if (n > 100) begin chk("req_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
    bus.pe_req_valid = 1'b0;
    acc_cyc = cyc;
    for (int i = 0; i < nsend; i++) begin
      bus.pe_data       = pay[i];
      bus.pe_data_valid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        ok = bus.pe_data_ready;
        @(posedge clk); #1;
        if (ok) break;
        n++;
        if (n > 100) begin chk("data_timeout", 32'd0, 32'd1); break; end
      end
      bus.pe_data_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      if (n > 200) begin chk("idle_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int fb;
    int vb;
    int rb;
    total = 0; bad = 0;
    rst = 1'b1;
    bus.pe_req_valid = 1'b0; bus.pe_dst_x = '0; bus.pe_dst_y = '0; bus.pe_len = '0;
    bus.pe_data_valid = 1'b0; bus.pe_data = '0; bus.FULL_IN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_rst", 32'(bus.pe_req_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_data", bus.DATA_OUT, 32'd0);
    chk("rst_valid", 32'(bus.DATA_VALID_OUT), 32'd0);
    chk("rst_done", 32'(bus.tx_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.pe_req_ready), 32'd1);
    @(posedge clk); #1;

    // Packet to (1,3), two payload words.
    b = q_flit.size();
    pay[0] = 30'h1; pay[1] = 30'h2;
    send_pkt(1'b1, 2'd3, 4'd2, 2, 0);
    wait_idle();
    $display("pkt len2: flits=%0d", q_flit.size() - b);
    chk("p1_count", 32'(q_flit.size() - b), 32'd3);
    chk("p1_latency", 32'(q_cyc[b] - acc_cyc), 32'd1);
    chk("p1_head", q_flit[b], 32'h7820_0000);
    chk("p1_body", q_flit[b+1], 32'h0000_0001);
    chk("p1_tail", q_flit[b+2], 32'h8000_0002);
    chk("p1_done_head", 32'(q_done[b]), 32'd0);
    chk("p1_done_tail", 32'(q_done[b+2]), 32'd1);
    chk("p1_back2back", 32'(q_cyc[b+2] - q_cyc[b+1]), 32'd1);
    chk("p1_busy_after", 32'(bus.busy), 32'd0);

    // Headtail packet to (0,1) after reset so seq restarts at 0.
    do_reset();
    b = q_flit.size(); rb = ready_hi;
    send_pkt(1'b0, 2'd1, 4'd0, 0, 0);
    wait_idle();
    $display("pkt len0: flits=%0d", q_flit.size() - b);
    chk("p2_count", 32'(q_flit.size() - b), 32'd1);
    chk("p2_flit", q_flit[b], 32'hC800_0000);
    chk("p2_done", 32'(q_done[b]), 32'd1);
    chk("p2_no_data_ready", 32'(ready_hi - rb), 32'd0);

    // len=4 with FULL held high for three edges right after the head.
    b = q_flit.size(); fb = full_cycles; vb = viol_valid; rb = viol_ready;
    pay[0] = 30'hA; pay[1] = 30'hB; pay[2] = 30'hC; pay[3] = 30'hD;
    fork
      send_pkt(1'b1, 2'd0, 4'd4, 4, 0);
      begin
        int n;
        n = 0;
        while (!bus.DATA_VALID_OUT && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.FULL_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.FULL_IN = 1'b0;
      end
    join
    wait_idle();
    $display("pkt len4 full: flits=%0d", q_flit.size() - b);
    chk("p3_count", 32'(q_flit.size() - b), 32'd5);
    chk("p3_head", q_flit[b], 32'h6040_1000);
    chk("p3_body0", q_flit[b+1], 32'h0000_000A);
    chk("p3_body1", q_flit[b+2], 32'h0000_000B);
    chk("p3_body2", q_flit[b+3], 32'h0000_000C);
    chk("p3_tail", q_flit[b+4], 32'h8000_000D);
    chk("p3_full_cycles", 32'(full_cycles - fb), 32'd3);
    chk("p3_valid_while_full", 32'(viol_valid - vb), 32'd0);
    chk("p3_ready_while_full", 32'(viol_ready - rb), 32'd0);

    // len=3 with payload valid every other cycle.
    b = q_flit.size();
    pay[0] = 30'h11; pay[1] = 30'h22; pay[2] = 30'h33;
    send_pkt(1'b0, 2'd2, 4'd3, 3, 1);
    wait_idle();
    $display("pkt len3 gaps: flits=%0d", q_flit.size() - b);
    chk("p4_count", 32'(q_flit.size() - b), 32'd4);
    chk("p4_head", q_flit[b], 32'h5030_2000);
    chk("p4_body0", q_flit[b+1], 32'h0000_0011);
    chk("p4_body1", q_flit[b+2], 32'h0000_0022);
    chk("p4_tail", q_flit[b+3], 32'h8000_0033);
    chk("p4_bubble", 32'(q_cyc[b+2] - q_cyc[b+1] > 1), 32'd1);
    chk("p4_done_tail", 32'(q_done[b+3]), 32'd1);

    // 257 headtail packets: seq runs 0..255 and wraps to 0.
    do_reset();
    b = q_flit.size();
    for (int i = 0; i < 257; i++) begin
      send_pkt(1'b0, 2'd0, 4'd0, 0, 0);
      wait_idle();
    end
    $display("seq wrap: flits=%0d", q_flit.size() - b);
    chk("wrap_count", 32'(q_flit.size() - b), 32'd257);
    for (int i = 0; i < 257; i++)
      chk($sformatf("wrap_seq%0d", i), q_flit[b+i], 32'hC000_0000 | (32'(i % 256) << 12));

    // Reset in BODY after one of three payload words.
    b = q_flit.size();
    pay[0] = 30'h5;
    send_pkt(1'b1, 2'd1, 4'd3, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", 32'(bus.DATA_VALID_OUT), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    $display("abort: flits=%0d", q_flit.size() - b);
    chk("abort_count", 32'(q_flit.size() - b), 32'd2);
    chk("abort_head", q_flit[b], 32'h6830_1000);
    chk("abort_no_tail", 32'(q_done[b+1]), 32'd0);
    b = q_flit.size();
    send_pkt(1'b0, 2'd0, 4'd0, 0, 0);
    wait_idle();
    $display("post-abort pkt: flits=%0d", q_flit.size() - b);
    chk("post_abort_count", 32'(q_flit.size() - b), 32'd1);
    chk("post_abort_seq0", q_flit[b], 32'hC000_0000);
    chk("stray_done", 32'(stray_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
